// File: rtl/tick_time_gen_pkg.sv
// Shared constants, debouncer state encoding and green-time saturation helper.
// Latency: n/a (package only).
// Backpressure: n/a; processor reads are strobe-qualified and never stall.
package tick_time_gen_pkg;

  // Green-phase length limits and the power-on value, in seconds.
  localparam logic [5:0] GT_MIN     = 6'd5;
  localparam logic [5:0] GT_MAX     = 6'd60;
  localparam logic [5:0] GT_DEFAULT = 6'd20;

  // Processor port map.
  localparam logic [7:0] PORT_CE = 8'd1;  // tick flag, read clears it
  localparam logic [7:0] PORT_GT = 8'd2;  // green-phase length

  // Button debouncer states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // released and stable
    PRESS_CHK = 2'd1,  // level went high, counting stable high samples
    HELD      = 2'd2,  // press accepted, waiting for release
    REL_CHK   = 2'd3   // level went low, counting stable low samples
  } db_state_t;

  // Next green time for one pair of press events. Opposing events in the
  // same cycle cancel; each direction saturates at its limit.
  function automatic logic [5:0] gt_next(input logic [5:0] gt,
                                         input logic       up,
                                         input logic       dn);
    logic [5:0] nxt;
    nxt = gt;
    if (up && !dn) begin
      if (gt < GT_MAX) nxt = gt + 6'd1;
    end else if (dn && !up) begin
      if (gt > GT_MIN) nxt = gt - 6'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tick_time_gen_btn_debounce.sv
// Purpose: 2-flop synchronizer plus press/release debounce FSM for one raw button.
// Latency: press pulse DEBOUNCE_CYC+2 edges after the first edge sampling btn=1.
// Backpressure: none; emits one registered single-cycle pulse per accepted press.
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   btn    raw asynchronous button level, high = pressed
//   press  one-cycle pulse when a press has been stable for DEBOUNCE_CYC samples
module btn_debounce
  import tick_time_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  // Counter holds values 0..DEBOUNCE_CYC-1.
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  // With a one-sample window the check states are skipped entirely.
  localparam bit SINGLE = (DEBOUNCE_CYC <= 1);

  logic [1:0]    sync;
  logic          lvl;
  db_state_t     state;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer; sync[1] is the only copy the FSM looks at.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], btn};
    end
  end

  assign lvl = sync[1];

  // The sample that moves IDLE->PRESS_CHK (or HELD->REL_CHK) already counts
  // as the first stable sample, so the counter starts at 1 on entry. That is
  // what puts the press pulse DEBOUNCE_CYC+2 edges after the raw edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        IDLE: begin
          if (lvl) begin
            if (SINGLE) begin
              state <= HELD;
              press <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= PRESS_CHK;
              cnt   <= CW'(1);
            end
          end
        end

        PRESS_CHK: begin
          if (!lvl) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= HELD;
            press <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // No counting while held: a long press never repeats.
        HELD: begin
          if (!lvl) begin
            if (SINGLE) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              state <= REL_CHK;
              cnt   <= CW'(1);
            end
          end
        end

        // A high sample here is contact bounce on release; go back to HELD
        // so the same physical press cannot produce a second event.
        REL_CHK: begin
          if (lvl) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tick_time_gen.sv
// Purpose: tick prescaler with sticky ce/overrun flags and button-adjusted green-phase time.
// Latency: ce one edge after the internal tick; greenLightTime DEBOUNCE_CYC+3 edges after a button edge.
// Backpressure: none; a port-1 read clears the flags, ticks arriving while ce is pending set tick_overrun.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   port_id         processor port address
//   read_strobe     processor read qualifier, one cycle per read
//   btn_up/btn_down raw asynchronous buttons, high = pressed
//   ce              sticky tick flag (port 1)
//   greenLightTime  green phase length in seconds (port 2)
//   tick_overrun    sticky flag: a tick came while ce was still pending
module tick_time_gen
  import tick_time_gen_pkg::*;
#(
  parameter int TICK_DIV     = 100000000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       ce,
  output logic [5:0] greenLightTime,
  output logic       tick_overrun
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          clr_rd;
  logic          up_evt;
  logic          dn_evt;

  // Prescaler: counts 0..TICK_DIV-1. The tick is internal only; nothing
  // outside sees it except through the registered ce flag.
  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Reading the ce port acknowledges the pending tick.
  assign clr_rd = read_strobe && (port_id == PORT_CE);

  // A tick always wins over a same-cycle acknowledge so a tick is never
  // lost. In that collision the acknowledge is void, so tick_overrun holds
  // its value: the read consumed the old tick, the new one is still pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce           <= 1'b0;
      tick_overrun <= 1'b0;
    end else if (tick) begin
      ce <= 1'b1;
      if (ce && !clr_rd) tick_overrun <= 1'b1;
    end else if (clr_rd) begin
      ce           <= 1'b0;
      tick_overrun <= 1'b0;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db_up (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_up),
    .press(up_evt)
  );

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db_down (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_down),
    .press(dn_evt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      greenLightTime <= GT_DEFAULT;
    end else begin
      greenLightTime <= gt_next(greenLightTime, up_evt, dn_evt);
    end
  end

endmodule

// File: tb/tb_tick_time_gen.sv
// Purpose: directed self-checking bench for tick_time_gen (TICK_DIV=10, DEBOUNCE_CYC=4).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_tick_time_gen;

  localparam int TD = 10;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] port_id = 8'd0;
  logic       read_strobe = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       ce;
  logic [5:0] greenLightTime;
  logic       tick_overrun;

  int n_chk  = 0;
  int n_fail = 0;

  tick_time_gen #(
    .TICK_DIV    (TD),
    .DEBOUNCE_CYC(DC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .port_id       (port_id),
    .read_strobe   (read_strobe),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .ce            (ce),
    .greenLightTime(greenLightTime),
    .tick_overrun  (tick_overrun)
  );

  always #5 clk = ~clk;

  // Flag-test vector: idle cycles first, then one cycle with the given
  // read inputs, then the expected flags after that edge.
  typedef struct {
    int         idle;
    logic [7:0] pid;
    logic       rd;
    logic       exp_ce;
    logic       exp_ovr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(int idle, int pid, bit rd, bit c, bit o);
    vec_t v;
    v.idle    = idle;
    v.pid     = 8'(pid);
    v.rd      = rd;
    v.exp_ce  = c;
    v.exp_ovr = o;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Async assert mid-cycle, check outputs before any edge, release 1 unit
  // after an edge so the next edge is edge 1 of the new run.
  task automatic reset_dut(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check({tag, " rst ce"}, int'(ce), 0);
    check({tag, " rst ovr"}, int'(tick_overrun), 0);
    check({tag, " rst gt"}, int'(greenLightTime), 20);
    step();
    rst = 1'b1;
  endtask

  task automatic press(input bit up, input bit dn);
    btn_up   = up;
    btn_down = dn;
    repeat (8) step();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (10) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: end of test not reached, got timeout, expected finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int exp_gt;

    // Edge numbers in comments count from the first edge after release.
    vt.push_back(mk(0, 0, 0, 0, 0));  // E1
    vt.push_back(mk(7, 0, 0, 0, 0));  // E9: last edge before ce
    vt.push_back(mk(0, 0, 0, 1, 0));  // E10: first tick lands
    vt.push_back(mk(8, 0, 0, 1, 0));  // E19
    vt.push_back(mk(0, 0, 0, 1, 1));  // E20: second tick, ce still pending
    vt.push_back(mk(4, 2, 1, 1, 1));  // E25: read of port 2 changes nothing
    vt.push_back(mk(0, 1, 0, 1, 1));  // E26: port 1 without strobe
    vt.push_back(mk(0, 1, 1, 0, 0));  // E27: clearing read
    vt.push_back(mk(2, 1, 1, 1, 0));  // E30: tick + read, ce was 0
    vt.push_back(mk(9, 1, 1, 1, 0));  // E40: tick + read with ce=1, set wins
    vt.push_back(mk(1, 1, 1, 0, 0));  // E42: read two cycles later
    vt.push_back(mk(7, 0, 0, 1, 0));  // E50
    vt.push_back(mk(9, 0, 0, 1, 1));  // E60: overrun
    vt.push_back(mk(9, 1, 1, 1, 1));  // E70: tick + read, overrun unchanged
    vt.push_back(mk(0, 1, 1, 0, 0));  // E71: read clears both
    vt.push_back(mk(3, 1, 1, 0, 0));  // E75: read with nothing pending

    // Power-on reset held across edges.
    repeat (2) @(posedge clk);
    #1;
    check("por ce", int'(ce), 0);
    check("por ovr", int'(tick_overrun), 0);
    check("por gt", int'(greenLightTime), 20);
    rst = 1'b1;

    // Tick / flag table.
    foreach (vt[i]) begin
      repeat (vt[i].idle) step();
      port_id     = vt[i].pid;
      read_strobe = vt[i].rd;
      step();
      port_id     = 8'd0;
      read_strobe = 1'b0;
      check($sformatf("vec%0d ce", i), int'(ce), int'(vt[i].exp_ce));
      check($sformatf("vec%0d ovr", i), int'(tick_overrun), int'(vt[i].exp_ovr));
      check($sformatf("vec%0d gt", i), int'(greenLightTime), 20);
    end

    // Held button: change exactly DC+3 = 7 edges after first sample, once.
    reset_dut("held");
    btn_up = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("held e%0d gt", k), int'(greenLightTime), (k >= 7) ? 21 : 20);
    end
    btn_up = 1'b0;
    repeat (10) step();
    check("held after release gt", int'(greenLightTime), 21);

    // Bounce 1,0,1,0 at 2-cycle spacing, never DC stable highs.
    reset_dut("bounce");
    for (int k = 0; k < 28; k++) begin
      btn_up = (k < 2 || (k >= 4 && k < 6)) ? 1'b1 : 1'b0;
      step();
      check($sformatf("bounce e%0d gt", k + 1), int'(greenLightTime), 20);
    end

    // Saturation at both ends.
    reset_dut("sat");
    exp_gt = 20;
    for (int k = 1; k <= 41; k++) begin
      press(1'b1, 1'b0);
      exp_gt = (exp_gt < 60) ? exp_gt + 1 : 60;
      check($sformatf("up press %0d gt", k), int'(greenLightTime), exp_gt);
    end
    check("up sat gt", int'(greenLightTime), 60);
    for (int k = 1; k <= 60; k++) begin
      press(1'b0, 1'b1);
      exp_gt = (exp_gt > 5) ? exp_gt - 1 : 5;
      check($sformatf("down press %0d gt", k), int'(greenLightTime), exp_gt);
    end
    check("down sat gt", int'(greenLightTime), 5);

    // Simultaneous up and down cancel.
    reset_dut("both");
    press(1'b1, 1'b1);
    check("both gt", int'(greenLightTime), 20);
    press(1'b1, 1'b0);
    check("up after both gt", int'(greenLightTime), 21);

    // Reset in the middle of PRESS_CHK: gt back to 20 at once, no event.
    btn_up = 1'b1;
    repeat (4) step();
    check("pre-abort gt", int'(greenLightTime), 21);
    #3;
    rst = 1'b0;
    #1;
    check("abort async gt", int'(greenLightTime), 20);
    check("abort async ce", int'(ce), 0);
    btn_up = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      check($sformatf("abort e%0d gt", k), int'(greenLightTime), 20);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_time_gen.md
TICK_TIME_GEN -- requirements
Module: tick_time_gen

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per tick period.
REQ-002 Parameter DEBOUNCE_CYC, default 1000000, consecutive stable cycles required to accept a button level.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 port_id  input  8  processor port address.
REQ-006 read_strobe  input  1  processor read qualifier, one cycle per read.
REQ-007 btn_up  input  1  raw asynchronous button, high = pressed.
REQ-008 btn_down  input  1  raw asynchronous button, high = pressed.
REQ-009 ce  output  1  sticky tick flag, read through port 1.
REQ-010 greenLightTime  output  6  green phase length in seconds, read through port 2.
REQ-011 tick_overrun  output  1  sticky flag: a tick arrived while ce was still pending.

Function
REQ-012 Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; an internal one-cycle tick SHALL be asserted in the cycle where the count equals TICK_DIV-1.
REQ-013 ce SHALL go to 1 on the clock edge following a tick.
REQ-014 ce SHALL be cleared to 0 on the clock edge following a cycle with read_strobe=1 and port_id=1.
REQ-015 Tick and clearing read in the same cycle: set wins, ce stays 1, tick_overrun unchanged.
REQ-016 tick_overrun SHALL go to 1 when a tick occurs while ce=1 and no clearing read is present in that cycle.
REQ-017 tick_overrun SHALL be cleared by the same clearing read as ce, unless REQ-016 sets it in that cycle.
REQ-018 Reads with port_id other than 1 SHALL NOT affect ce or tick_overrun.
REQ-019 Each button SHALL pass through a 2-flop synchronizer before debouncing.
REQ-020 Debouncer FSM states: IDLE, PRESS_CHK, HELD, REL_CHK.
REQ-021 IDLE -> PRESS_CHK on synchronized level 1.
REQ-022 PRESS_CHK -> HELD after DEBOUNCE_CYC consecutive 1 samples, emitting a one-cycle press event; any 0 sample returns to IDLE.
REQ-023 HELD -> REL_CHK on 0.
REQ-024 REL_CHK -> IDLE after DEBOUNCE_CYC consecutive 0 samples; any 1 sample returns to HELD.
REQ-025 A held button SHALL produce exactly one event (no auto-repeat).
REQ-026 Up event SHALL increment greenLightTime by 1, saturating at GT_MAX=60.
REQ-027 Down event SHALL decrement greenLightTime by 1, saturating at GT_MIN=5.
REQ-028 Up and down events in the same cycle SHALL leave greenLightTime unchanged.
REQ-029 With a clean button edge held stable, greenLightTime SHALL change exactly DEBOUNCE_CYC+3 clk edges after the first edge sampling btn=1.
REQ-030 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-031 rst=0 SHALL asynchronously force: prescaler=0, ce=0, tick_overrun=0, greenLightTime=GT_DEFAULT=20, synchronizers=0, debouncers=IDLE with counters=0.
REQ-032 Reset during PRESS_CHK or REL_CHK SHALL discard the pending press without an event.
REQ-033 The first tick after release of reset SHALL occur TICK_DIV cycles after the first active clock edge.

Structure
REQ-034 A shared package SHALL hold GT_MIN, GT_MAX, GT_DEFAULT, PORT_CE=1, PORT_GT=2 and the debouncer state enumeration.
REQ-035 The debouncer SHALL be a sub-module, btn_debounce (synchronizer + FSM + counter), instantiated twice.
REQ-036 The prescaler, flag logic and greenLightTime register SHALL reside in tick_time_gen.

Verification (TICK_DIV=10, DEBOUNCE_CYC=4)
REQ-037 Release reset, no reads -> ce rises after 10 cycles; tick_overrun rises at cycle 20 and stays 1.
REQ-038 Read port 1 in the same cycle as a tick -> ce remains 1 and tick_overrun is unchanged; read port 1 two cycles later -> ce=0, tick_overrun=0.
REQ-039 btn_up held 20 cycles from reset -> greenLightTime goes 20->21 exactly 7 edges after the first sample; no further change while held.
REQ-040 btn_up bounced 1,0,1,0 at 2-cycle spacing, then low -> greenLightTime stays 20.
REQ-041 41 clean up presses -> greenLightTime = 60; 60 clean down presses -> greenLightTime = 5.
REQ-042 Both buttons pressed simultaneously -> greenLightTime unchanged; assert rst mid PRESS_CHK -> greenLightTime=20, no event after release.
